// File: rtl/accum_dump_pkg.sv
// Shared default widths for the accumulate-and-dump datapath and its rounding stage.
package accum_dump_pkg;
   localparam int DEF_WIDTH_IN  = 48;
   localparam int DEF_WIDTH_ACC = 56;
   localparam int DEF_WIDTH_OUT = 32;
   localparam int DEF_SHIFT     = 16;
   localparam int DEF_WIDTH_LEN = 16;
endpackage

// File: rtl/accum_dump_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation to a narrower signed width.
module accum_dump_round_sat
   import accum_dump_pkg::*;
#(
   parameter int WIDTH_IN  = DEF_WIDTH_ACC,
   parameter int WIDTH_OUT = DEF_WIDTH_OUT,
   parameter int SHIFT     = DEF_SHIFT
) (
   input  logic [WIDTH_IN-1:0]  din,
   output logic [WIDTH_OUT-1:0] dout,
   output logic                 clip
);
   localparam int RSH = (SHIFT == 0) ? 0 : SHIFT - 1;
   localparam logic signed [WIDTH_IN:0] RND =
      (SHIFT == 0) ? '0 : ({{WIDTH_IN{1'b0}}, 1'b1} << RSH);
   localparam logic signed [WIDTH_IN:0] OUT_MAX =
      {{(WIDTH_IN + 2 - WIDTH_OUT){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
   localparam logic signed [WIDTH_IN:0] OUT_MIN =
      {{(WIDTH_IN + 2 - WIDTH_OUT){1'b1}}, {(WIDTH_OUT - 1){1'b0}}};

   // One guard bit so the rounding add can never wrap.
   logic signed [WIDTH_IN:0] ext;
   logic signed [WIDTH_IN:0] rsum;
   logic signed [WIDTH_IN:0] r;

   always_comb begin
      ext  = {din[WIDTH_IN-1], din};
      rsum = ext + RND;
      r    = rsum >>> SHIFT;
      clip = 1'b0;
      dout = r[WIDTH_OUT-1:0];
      if (r > OUT_MAX) begin
         dout = {1'b0, {(WIDTH_OUT - 1){1'b1}}};
         clip = 1'b1;
      end else if (r < OUT_MIN) begin
         dout = {1'b1, {(WIDTH_OUT - 1){1'b0}}};
         clip = 1'b1;
      end
   end
endmodule

// File: rtl/accum_dump.sv
// Sums signed product beats per packet or per len-beat block and emits one rounded, saturated beat per dump.
module accum_dump
   import accum_dump_pkg::*;
#(
   parameter int WIDTH_IN  = DEF_WIDTH_IN,
   parameter int WIDTH_ACC = DEF_WIDTH_ACC,
   parameter int WIDTH_OUT = DEF_WIDTH_OUT,
   parameter int SHIFT     = DEF_SHIFT,
   parameter int WIDTH_LEN = DEF_WIDTH_LEN
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [WIDTH_LEN-1:0] len,
   input  logic [WIDTH_IN-1:0]  i_tdata,
   input  logic                 i_tlast,
   input  logic                 i_tvalid,
   output logic                 i_tready,
   output logic [WIDTH_OUT-1:0] o_tdata,
   output logic                 o_tlast,
   output logic                 o_tvalid,
   input  logic                 o_tready,
   output logic                 o_clip
);
   logic [WIDTH_ACC-1:0] acc;
   logic [WIDTH_ACC-1:0] sum;
   logic [WIDTH_LEN-1:0] cnt;
   logic                 take;
   logic                 dump;
   logic [WIDTH_OUT-1:0] rs_dat;
   logic                 rs_clip;

   // Single holding register: accept while it is empty or draining this cycle.
   assign i_tready = reset & ~clear & (~o_tvalid | o_tready);
   assign take     = i_tvalid & i_tready;
   assign sum      = acc + WIDTH_ACC'(signed'(i_tdata));
   assign dump     = i_tlast | ((len != '0) & (cnt == len - WIDTH_LEN'(1)));

   accum_dump_round_sat #(
      .WIDTH_IN  (WIDTH_ACC),
      .WIDTH_OUT (WIDTH_OUT),
      .SHIFT     (SHIFT)
   ) u_round_sat (
      .din  (sum),
      .dout (rs_dat),
      .clip (rs_clip)
   );

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         acc      <= '0;
         cnt      <= '0;
         o_tdata  <= '0;
         o_tlast  <= 1'b0;
         o_tvalid <= 1'b0;
         o_clip   <= 1'b0;
      end else begin
         if (o_tvalid && o_tready) begin
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
         end
         // A dump in the same cycle as a drain reloads the register without a bubble.
         if (take) begin
            if (dump) begin
               o_tdata  <= rs_dat;
               o_tlast  <= 1'b1;
               o_tvalid <= 1'b1;
               acc      <= '0;
               cnt      <= '0;
               if (rs_clip) o_clip <= 1'b1;
            end else begin
               acc <= sum;
               cnt <= cnt + WIDTH_LEN'(1);
            end
         end
      end
   end
endmodule
